// File: rtl/vote_console_driver.sv
// Host-side driver that turns single-cycle vote/read requests into timed button/mode sequences.
// Optional macro VOTE_AUDIT_EN adds per-candidate shadow counters and a read-audit mismatch flag.
module vote_console_driver #(
    parameter int HOLD_CYCLES   = 110,
    parameter int GAP_CYCLES    = 25,
    parameter int SETTLE_CYCLES = 10,
    parameter int TIMER_W       = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_op,
    input  logic [1:0] req_cand,
    output logic       resp_valid,
    output logic       resp_op,
    output logic [7:0] resp_count,
    output logic       resp_mismatch,
    output logic       vm_mode,
    output logic       vm_button1,
    output logic       vm_button2,
    output logic       vm_button3,
    output logic       vm_button4,
    input  logic [7:0] vm_led
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS    = 3'd1,
        MODE_SET = 3'd2,
        SHOW     = 3'd3,
        RELEASE  = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [TIMER_W-1:0] HOLD_LOAD   = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD    = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);

    state_t             state;
    state_t             next_state;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_next;
    logic               op_q;
    logic [1:0]         cand_q;
    logic               accept;
    logic               op_n;
    logic [1:0]         cand_n;
    logic               mode_d;
    logic [3:0]         buttons_d;
    logic [3:0]         buttons_q;

    assign accept = (state == IDLE) && req_valid;

    // State, phase timer and latched request
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            timer  <= '0;
            op_q   <= 1'b0;
            cand_q <= 2'd0;
        end else begin
            state <= next_state;
            timer <= timer_next;
            if (accept) begin
                op_q   <= req_op;
                cand_q <= req_cand;
            end else begin
                op_q   <= op_q;
                cand_q <= cand_q;
            end
        end
    end

    // Next state; the timer reloads N-1 whenever a new phase is entered
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (req_valid) next_state = req_op ? MODE_SET : PRESS;
                      else           next_state = IDLE;
            PRESS:    if (timer == '0) next_state = RELEASE; else next_state = PRESS;
            MODE_SET: if (timer == '0) next_state = SHOW;    else next_state = MODE_SET;
            SHOW:     if (timer == '0) next_state = RELEASE; else next_state = SHOW;
            RELEASE:  if (timer == '0) next_state = DONE;    else next_state = RELEASE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
        timer_next = timer;
        if (next_state != state) begin
            case (next_state)
                PRESS:    timer_next = HOLD_LOAD;
                MODE_SET: timer_next = SETTLE_LOAD;
                SHOW:     timer_next = SETTLE_LOAD;
                RELEASE:  timer_next = GAP_LOAD;
                default:  timer_next = '0;
            endcase
        end else if (timer != '0) begin
            timer_next = timer - TIMER_W'(1);
        end else begin
            timer_next = timer;
        end
    end

    // Output values for the upcoming state, so the registered outputs line up with it
    always_comb begin
        op_n      = accept ? req_op : op_q;
        cand_n    = accept ? req_cand : cand_q;
        mode_d    = 1'b0;
        buttons_d = 4'b0000;
        case (next_state)
            PRESS:    buttons_d = 4'(4'b0001 << cand_n);
            MODE_SET: mode_d    = 1'b1;
            SHOW: begin
                mode_d    = 1'b1;
                buttons_d = 4'(4'b0001 << cand_n);
            end
            RELEASE:  mode_d    = op_n;
            default:  mode_d    = 1'b0;
        endcase
    end

    // Registered host and panel outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_op    <= 1'b0;
            resp_count <= 8'h00;
            vm_mode    <= 1'b0;
            buttons_q  <= 4'b0000;
        end else begin
            req_ready  <= (next_state == IDLE);
            resp_valid <= (next_state == DONE);
            vm_mode    <= mode_d;
            buttons_q  <= buttons_d;
            if (next_state == DONE) resp_op <= op_q;
            else                    resp_op <= resp_op;
            if (state == SHOW && timer == '0) resp_count <= vm_led;
            else                              resp_count <= resp_count;
        end
    end

    assign vm_button1 = buttons_q[0];
    assign vm_button2 = buttons_q[1];
    assign vm_button3 = buttons_q[2];
    assign vm_button4 = buttons_q[3];

`ifdef VOTE_AUDIT_EN
    logic [7:0] shadow [4];
    logic       mismatch_q;

    // Shadow tallies advance on vote completion; reads compare the captured led against them
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) shadow[i] <= 8'h00;
            mismatch_q <= 1'b0;
        end else if (state == RELEASE && next_state == DONE) begin
            if (op_q) mismatch_q <= (resp_count != shadow[cand_q]);
            else      shadow[cand_q] <= shadow[cand_q] + 8'd1;
        end else begin
            mismatch_q <= mismatch_q;
        end
    end

    assign resp_mismatch = mismatch_q;
`else
    assign resp_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_vote_console_driver.sv
// Directed bench for vote_console_driver with a behavioural voting-machine model and response scoreboard.
module tb_vote_console_driver;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_op = 1'b0;
    logic [1:0] req_cand = 2'd0;
    logic       req_ready, resp_valid, resp_op, resp_mismatch, vm_mode;
    logic       vm_button1, vm_button2, vm_button3, vm_button4;
    logic [7:0] resp_count;
    logic [7:0] vm_led;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       op;
        logic [7:0] cnt;
        logic       mm;
    } exp_t;
    exp_t sb[$];

    logic [7:0] tally [4];
    logic [7:0] exp_cnt;
    logic       exp_mm;
    bit         led_force = 1'b0;
    logic [7:0] led_force_val = 8'h00;

    logic [7:0] vm_cnt [4];
    int         hold [4];
    int         btn_len [4];
    int         btn_run [4];
    int         mode_len = 0;
    int         mode_run = 0;
    logic [3:0] btn;

    assign btn = {vm_button4, vm_button3, vm_button2, vm_button1};

    vote_console_driver dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_cand(req_cand),
        .resp_valid(resp_valid), .resp_op(resp_op), .resp_count(resp_count),
        .resp_mismatch(resp_mismatch), .vm_mode(vm_mode),
        .vm_button1(vm_button1), .vm_button2(vm_button2),
        .vm_button3(vm_button3), .vm_button4(vm_button4), .vm_led(vm_led)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Voting machine model: a press held >=100 clocks in vote mode counts on release
    always @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin vm_cnt[k] <= 8'h00; hold[k] <= 0; end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (btn[k]) hold[k] <= hold[k] + 1;
                else begin
                    if (hold[k] >= 100 && !vm_mode) vm_cnt[k] <= vm_cnt[k] + 8'd1;
                    hold[k] <= 0;
                end
            end
        end
    end

    always_comb begin
        vm_led = 8'h00;
        if (led_force) vm_led = led_force_val;
        else if (vm_mode) begin
            for (int k = 0; k < 4; k++) if (btn[k]) vm_led = vm_cnt[k];
        end
    end

    // Monitor: one-hot buttons, run lengths, scoreboard pop on responses
    always @(negedge clock) begin
        if (!reset) begin
            check("onehot", ($countones(btn) <= 1) ? 32'd1 : 32'd0, 32'd1);
            for (int m = 0; m < 4; m++) begin
                if (btn[m]) btn_len[m] = btn_len[m] + 1;
                else if (btn_len[m] > 0) begin btn_run[m] = btn_len[m]; btn_len[m] = 0; end
            end
            if (vm_mode) mode_len = mode_len + 1;
            else if (mode_len > 0) begin mode_run = mode_len; mode_len = 0; end
            if (resp_valid) begin
                if (sb.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_op", resp_op, e.op);
                    check("resp_count", resp_count, e.cnt);
                    check("resp_mismatch", resp_mismatch, e.mm);
                end
            end
        end
    end

    task automatic push_exp(input logic op, input logic [1:0] cand);
        exp_t e;
        if (op) begin
            exp_cnt = led_force ? led_force_val : tally[cand];
`ifdef VOTE_AUDIT_EN
            exp_mm = (exp_cnt != tally[cand]);
`endif
        end else begin
            tally[cand] = tally[cand] + 8'd1;
        end
        e.op = op; e.cnt = exp_cnt; e.mm = exp_mm;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin tally[k] = 8'h00; btn_len[k] = 0; btn_run[k] = 0; end
        exp_cnt = 8'h00; exp_mm = 1'b0; mode_len = 0; mode_run = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic issue(input logic op, input logic [1:0] cand, input bit push);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 300) begin @(negedge clock); n++; end
        check("ready_timeout", (n < 300) ? 32'd1 : 32'd0, 32'd1);
        if (push) push_exp(op, cand);
        req_valid = 1'b1; req_op = op; req_cand = cand;
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        bit saw_ready;
        lat = 0; saw_ready = 1'b0;
        do begin
            @(negedge clock);
            lat++;
            if (req_ready) saw_ready = 1'b1;
        end while (!resp_valid && lat < 400);
        check("resp_seen", resp_valid, 1'b1);
        check("ready_low_busy", saw_ready, 1'b0);
    endtask

    task automatic run_op(input logic op, input logic [1:0] cand);
        int lat;
        issue(op, cand, 1'b1);
        wait_resp(lat);
        check(op ? "read_latency" : "vote_latency", lat, op ? 32'd46 : 32'd136);
        @(negedge clock);
        check("ready_after_done", req_ready, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic       ops [4];
        logic [1:0] cands [4];
        ops = '{1'b0, 1'b1, 1'b0, 1'b1};
        cands = '{2'd2, 2'd2, 2'd3, 2'd1};

        do_reset();
        check("rst_ready", req_ready, 1'b1);
        check("rst_valid", resp_valid, 1'b0);
        check("rst_op", resp_op, 1'b0);
        check("rst_count", resp_count, 8'h00);
        check("rst_mismatch", resp_mismatch, 1'b0);
        check("rst_mode", vm_mode, 1'b0);
        check("rst_buttons", btn, 4'b0000);

        // Single vote: 110 high, 25 low, response on cycle 136
        run_op(1'b0, 2'd0);
        check("vote_hold_len", btn_run[0], 32'd110);

        // Five votes then read candidate 0
        do_reset();
        run_op(1'b0, 2'd0); run_op(1'b0, 2'd1); run_op(1'b0, 2'd2);
        run_op(1'b0, 2'd3); run_op(1'b0, 2'd0);
        run_op(1'b1, 2'd0);
        check("read_mode_len", mode_run, 32'd45);
        check("read_press_len", btn_run[0], 32'd10);
        check("read_count_c0", resp_count, 8'h02);

        // Forced led value is captured and survives a later vote
        led_force = 1'b1; led_force_val = 8'h5A;
        run_op(1'b1, 2'd2);
        led_force = 1'b0;
        run_op(1'b0, 2'd1);
        check("count_held", resp_count, 8'h5A);

        // Back-to-back with req_valid held high
        push_exp(ops[0], cands[0]);
        req_valid = 1'b1; req_op = ops[0]; req_cand = cands[0];
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            if (i < 3) begin
                push_exp(ops[i+1], cands[i+1]);
                req_op = ops[i+1]; req_cand = cands[i+1];
            end else begin
                req_valid = 1'b0;
            end
            wait_resp(lat);
            check("b2b_latency", lat, ops[i] ? 32'd46 : 32'd136);
            @(negedge clock);
            check("b2b_ready", req_ready, 1'b1);
        end

        // Reset 40 clocks into a vote press
        issue(1'b0, 2'd1, 1'b0);
        repeat (40) @(negedge clock);
        check("press_active", vm_button2, 1'b1);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin tally[k] = 8'h00; btn_len[k] = 0; end
        exp_cnt = 8'h00; exp_mm = 1'b0; mode_len = 0;
        @(negedge clock);
        reset = 1'b0;
        check("abort_buttons", btn, 4'b0000);
        check("abort_mode", vm_mode, 1'b0);
        check("abort_ready", req_ready, 1'b1);
        check("abort_valid", resp_valid, 1'b0);
        repeat (200) @(negedge clock);
        check("abort_no_resp", sb.size(), 32'd0);

        // Audit: three votes on candidate 3, honest then wrong led
        do_reset();
        run_op(1'b0, 2'd3); run_op(1'b0, 2'd3); run_op(1'b0, 2'd3);
        run_op(1'b1, 2'd3);
        check("audit_count", resp_count, 8'h03);
        led_force = 1'b1; led_force_val = 8'h04;
        run_op(1'b1, 2'd3);
        led_force = 1'b0;
`ifdef VOTE_AUDIT_EN
        check("audit_flag", resp_mismatch, 1'b1);
`else
        check("audit_flag", resp_mismatch, 1'b0);
`endif

        check("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
